// File: rtl/pipelined_adder_pkg.sv
// Shared types and helpers for the chunked pipelined adder sequencer.
package pipelined_adder_pkg;

    // Sequencer states: walk the chunk slices, drain the pipe, flag the result.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    // Widest chunk-select vector the onehot helper can produce.
    localparam int ONEHOT_MAX_W = 64;

    // One-hot vector with bit idx set; bits at or above width stay clear.
    function automatic logic [ONEHOT_MAX_W-1:0] onehot(input int idx, input int width);
        logic [ONEHOT_MAX_W-1:0] v;
        v = '0;
        for (int i = 0; i < ONEHOT_MAX_W; i++) begin
            v[i] = (i == idx) && (i < width);
        end
        return v;
    endfunction

endpackage

// File: rtl/pipelined_adder_seq_counter.sv
// Modulo-MAX counter with synchronous clear, count enable and terminal-count flag.
module mod_counter #(
    parameter int  MAX = 4,
    localparam int W   = (MAX > 1) ? $clog2(MAX) : 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         tc
);

    // Terminal count is an explicit compare so non-power-of-two MAX never wraps naturally.
    assign tc = (cnt == W'(MAX - 1));

    // Count 0..MAX-1 while enabled; clear has priority over counting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tc ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pipelined_adder_seq.sv
// Sequencer for the chunked pipelined adder: steps chunk slices, drains the
// pipeline, then strobes done. Single-shot or back-to-back continuous mode.
module pipelined_adder_seq
    import pipelined_adder_pkg::*;
#(
    parameter int  NUM_STAGES = 4,
    parameter int  PIPE_LAT   = 1,
    localparam int IDX_W      = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  GO,
    input  logic                  MODE,
    input  logic                  HALT,
    output logic                  EN,
    output logic [NUM_STAGES-1:0] SEL,
    output logic [IDX_W-1:0]      STAGE_IDX,
    output logic                  LAST,
    output logic                  ENO,
    output logic                  BUSY
);

    localparam bit HAS_DRAIN = (PIPE_LAT > 0);
    localparam int DRN_MAX   = HAS_DRAIN ? PIPE_LAT : 1;
    localparam int DRN_W     = (DRN_MAX > 1) ? $clog2(DRN_MAX) : 1;

    if (NUM_STAGES < 2 || PIPE_LAT < 0 || NUM_STAGES > ONEHOT_MAX_W) begin : g_bad_param
        $error("pipelined_adder_seq: NUM_STAGES must be 2..%0d and PIPE_LAT >= 0", ONEHOT_MAX_W);
    end

    seq_state_t             state;
    logic [IDX_W-1:0]       slice_cnt;
    logic                   slice_tc;
    logic                   drain_done;
    logic [ONEHOT_MAX_W-1:0] sel_full;

    // Slice index: advances every RUN cycle, held at zero in every other state.
    mod_counter #(.MAX(NUM_STAGES)) u_slice (
        .clk   (clk),
        .reset (reset),
        .clr   (state != RUN),
        .en    (state == RUN),
        .cnt   (slice_cnt),
        .tc    (slice_tc)
    );

    if (HAS_DRAIN) begin : g_drain
        logic [DRN_W-1:0] drain_cnt;
        logic             drain_tc;

        // Drain counter: runs only in DRAIN, wraps to zero at its terminal count.
        mod_counter #(.MAX(DRN_MAX)) u_drain (
            .clk   (clk),
            .reset (reset),
            .clr   (state != DRAIN),
            .en    (state == DRAIN),
            .cnt   (drain_cnt),
            .tc    (drain_tc)
        );

        // Terminal flag qualified by the count value itself; the two always agree.
        assign drain_done = drain_tc && (drain_cnt == DRN_W'(DRN_MAX - 1));
    end else begin : g_no_drain
        // No pipeline latency: DRAIN is never entered, so its exit condition is moot.
        assign drain_done = 1'b1;
    end

    // State register: GO only in IDLE, MODE/HALT only in DONE, HALT beats MODE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (GO) state <= RUN;
                RUN:     if (slice_tc) state <= HAS_DRAIN ? DRAIN : DONE;
                DRAIN:   if (drain_done) state <= DONE;
                DONE:    state <= (MODE && !HALT) ? RUN : IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Moore output decode from registered state and slice count only.
    always_comb begin
        EN        = 1'b0;
        SEL       = '0;
        STAGE_IDX = '0;
        LAST      = 1'b0;
        ENO       = 1'b0;
        BUSY      = 1'b0;
        sel_full  = onehot(int'(slice_cnt), NUM_STAGES);
        case (state)
            RUN: begin
                EN        = 1'b1;
                BUSY      = 1'b1;
                SEL       = sel_full[NUM_STAGES-1:0];
                STAGE_IDX = slice_cnt;
                LAST      = slice_tc;
            end
            DRAIN: begin
                EN   = 1'b1;
                BUSY = 1'b1;
            end
            DONE: begin
                ENO  = 1'b1;
                BUSY = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_pipelined_adder_seq.sv
// Self-checking bench for pipelined_adder_seq: defaults (4,1) plus (3,0) and (5,3).
module tb_pipelined_adder_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, go_a, go_bc, mode, halt;

    logic       en_a, last_a, eno_a, busy_a;
    logic [3:0] sel_a;
    logic [1:0] idx_a;
    logic       en_b, last_b, eno_b, busy_b;
    logic [2:0] sel_b;
    logic [1:0] idx_b;
    logic       en_c, last_c, eno_c, busy_c;
    logic [4:0] sel_c;
    logic [2:0] idx_c;

    pipelined_adder_seq u_dut_a (
        .clk(clk), .reset(reset), .GO(go_a), .MODE(mode), .HALT(halt),
        .EN(en_a), .SEL(sel_a), .STAGE_IDX(idx_a), .LAST(last_a), .ENO(eno_a), .BUSY(busy_a)
    );

    pipelined_adder_seq #(.NUM_STAGES(3), .PIPE_LAT(0)) u_dut_b (
        .clk(clk), .reset(reset), .GO(go_bc), .MODE(mode), .HALT(halt),
        .EN(en_b), .SEL(sel_b), .STAGE_IDX(idx_b), .LAST(last_b), .ENO(eno_b), .BUSY(busy_b)
    );

    pipelined_adder_seq #(.NUM_STAGES(5), .PIPE_LAT(3)) u_dut_c (
        .clk(clk), .reset(reset), .GO(go_bc), .MODE(mode), .HALT(halt),
        .EN(en_c), .SEL(sel_c), .STAGE_IDX(idx_c), .LAST(last_c), .ENO(eno_c), .BUSY(busy_c)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int q_a[$];
    int q_b[$];
    int q_c[$];
    int exp_b = 0;
    int exp_c = 0;
    int drn_b = 0;
    int drn_c = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [9:0] pack_a();
        return {en_a, sel_a, idx_a, last_a, eno_a, busy_a};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitors: ENO must land on the cycle pushed when GO was driven.
    always @(negedge clk) begin
        if (!reset) begin
            if (eno_a) begin
                chk("a_eno_expected", q_a.size() > 0, 1);
                if (q_a.size() > 0) chk("a_eno_cycle", cyc, q_a.pop_front());
            end
            if (eno_b) begin
                chk("b_eno_expected", q_b.size() > 0, 1);
                if (q_b.size() > 0) chk("b_eno_cycle", cyc, q_b.pop_front());
                chk("b_drain_cycles", drn_b, 0);
                drn_b <= 0;
            end else if (en_b && sel_b == 3'b000) begin
                drn_b <= drn_b + 1;
            end
            if (eno_c) begin
                chk("c_eno_expected", q_c.size() > 0, 1);
                if (q_c.size() > 0) chk("c_eno_cycle", cyc, q_c.pop_front());
                chk("c_drain_cycles", drn_c, 3);
                drn_c <= 0;
            end else if (en_c && sel_c == 5'b00000) begin
                drn_c <= drn_c + 1;
            end
            if (sel_b != 3'b000) begin
                chk("b_idx_seq", idx_b, exp_b);
                chk("b_idx_range", idx_b < 3, 1);
                chk("b_sel_decode", sel_b, 3'b001 << idx_b);
                chk("b_last", last_b, exp_b == 2);
                exp_b <= (exp_b == 2) ? 0 : exp_b + 1;
            end
            if (sel_c != 5'b00000) begin
                chk("c_idx_seq", idx_c, exp_c);
                chk("c_idx_range", idx_c < 5, 1);
                chk("c_sel_decode", sel_c, 5'b00001 << idx_c);
                chk("c_last", last_c, exp_c == 4);
                exp_c <= (exp_c == 4) ? 0 : exp_c + 1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       go;
        logic [9:0] exp;   // {EN, SEL[3:0], STAGE_IDX[1:0], LAST, ENO, BUSY}
    } vec_t;

    vec_t tbl[8];
    int   s;

    initial begin
        tbl[0] = '{1'b1, 10'b1_0001_00_0_0_1};
        tbl[1] = '{1'b0, 10'b1_0010_01_0_0_1};
        tbl[2] = '{1'b0, 10'b1_0100_10_0_0_1};
        tbl[3] = '{1'b0, 10'b1_1000_11_1_0_1};
        tbl[4] = '{1'b0, 10'b1_0000_00_0_0_1};
        tbl[5] = '{1'b0, 10'b0_0000_00_0_1_1};
        tbl[6] = '{1'b0, 10'b0_0000_00_0_0_0};
        tbl[7] = '{1'b0, 10'b0_0000_00_0_0_0};

        reset = 1'b1; go_a = 1'b0; go_bc = 1'b0; mode = 1'b0; halt = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_state_a", pack_a(), 10'd0);
        chk("reset_state_b", {en_b, sel_b, eno_b, busy_b}, 0);
        chk("reset_state_c", {en_c, sel_c, eno_c, busy_c}, 0);
        reset = 1'b0;
        @(negedge clk);

        // Async reset in the middle of RUN: outputs clear at once, no ENO afterwards.
        go_a = 1'b1;
        @(negedge clk);
        go_a = 1'b0;
        repeat (2) @(negedge clk);
        chk("t1_idx_before_reset", idx_a, 2);
        #1 reset = 1'b1;
        #1 chk("t1_async_clear", pack_a(), 10'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("t1_idle_after_reset", pack_a(), 10'd0);
        end

        // Single-shot at defaults, one-cycle GO pulse, table driven.
        for (int i = 0; i < 8; i++) begin
            go_a = tbl[i].go;
            if (tbl[i].go) q_a.push_back(cyc + 1 + 5);
            @(negedge clk);
            chk($sformatf("t2_vec%0d", i), pack_a(), tbl[i].exp);
        end
        go_a = 1'b0;

        // GO held high: ignored while busy, restart one idle cycle after ENO.
        go_a = 1'b1;
        s = cyc + 1;
        q_a.push_back(s + 5);
        q_a.push_back(s + 12);
        while (cyc < s + 6) @(negedge clk);
        chk("t3_idle_gap_busy", busy_a, 0);
        @(negedge clk);
        chk("t3_restart_sel", sel_a, 4'b0001);
        go_a = 1'b0;
        for (int k = 0; k < 40 && q_a.size() != 0; k++) @(negedge clk);
        chk("t3_queue_drained", q_a.size(), 0);
        repeat (2) @(negedge clk);
        chk("t3_idle_after", busy_a, 0);

        // Continuous mode: three results six cycles apart, HALT in the third DONE.
        mode = 1'b1; halt = 1'b0;
        go_a = 1'b1;
        s = cyc + 1;
        q_a.push_back(s + 5);
        q_a.push_back(s + 11);
        q_a.push_back(s + 17);
        @(negedge clk);
        go_a = 1'b0;
        while (cyc < s + 6) @(negedge clk);
        chk("t4_back_to_back_1", sel_a, 4'b0001);
        while (cyc < s + 12) @(negedge clk);
        chk("t4_back_to_back_2", sel_a, 4'b0001);
        while (cyc < s + 17) @(negedge clk);
        chk("t4_third_done", eno_a, 1);
        halt = 1'b1;
        @(negedge clk);
        chk("t4_halt_to_idle", {busy_a, en_a, sel_a}, 0);
        mode = 1'b0; halt = 1'b0;
        repeat (8) @(negedge clk);
        chk("t4_stays_idle", busy_a, 0);
        chk("t4_queue_drained", q_a.size(), 0);

        // Parameter sweep: (3,0) and (5,3) started together.
        go_bc = 1'b1;
        s = cyc + 1;
        q_b.push_back(s + 3);
        q_c.push_back(s + 8);
        @(negedge clk);
        go_bc = 1'b0;
        for (int k = 0; k < 40 && (q_b.size() != 0 || q_c.size() != 0); k++) @(negedge clk);
        chk("t5_b_queue_drained", q_b.size(), 0);
        chk("t5_c_queue_drained", q_c.size(), 0);
        repeat (2) @(negedge clk);
        chk("t5_b_idle", busy_b, 0);
        chk("t5_c_idle", busy_c, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
